// File: rtl/axi_stream_packetizer.sv
// ---------------------------------------------------------------------------
// axi_stream_packetizer
//
// Purpose:
//   Turns an unframed valid/ready word stream into a framed AXI-Stream.
//   master_last_out is asserted on every Nth beat, where N is pkt_len_in.
//   N is sampled on the first beat of each packet. flush_in closes the
//   current packet early on the beat it accompanies. All master-side outputs
//   come from registers through a two-entry skid buffer, so throughput stays
//   at one beat per clock and there is no combinational ready path.
//
// Ports:
//   clk              - clock, all logic on rising edge
//   rst              - asynchronous active-low reset
//   slave_data_in    - upstream data word
//   slave_valid_in   - upstream valid
//   slave_ready_in   - registered ready back to upstream
//   pkt_len_in       - beats per packet (0 is treated as 1)
//   flush_in         - end the packet on this accepted beat
//   master_data_out  - framed data to downstream
//   master_valid_out - downstream valid
//   master_last_out  - last beat of a packet
//   master_ready_out - downstream ready
//   pkt_count_out    - packets completed on the master side (wraps)
//   in_packet_out    - high while a packet is partially accepted
// ---------------------------------------------------------------------------
module axi_stream_packetizer #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_DATA_WIDTH-1:0] slave_data_in,
    input  logic                      slave_valid_in,
    output logic                      slave_ready_in,
    input  logic [LEN_WIDTH-1:0]      pkt_len_in,
    input  logic                      flush_in,
    output logic [AXI_DATA_WIDTH-1:0] master_data_out,
    output logic                      master_valid_out,
    output logic                      master_last_out,
    input  logic                      master_ready_out,
    output logic [CNT_WIDTH-1:0]      pkt_count_out,
    output logic                      in_packet_out
);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    state_t                    state_q, state_d;
    logic [LEN_WIDTH-1:0]      beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;

    logic [AXI_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                      out_last_q, out_last_d;
    logic                      out_valid_q, out_valid_d;
    logic [AXI_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                      skid_last_q, skid_last_d;
    logic                      skid_valid_q, skid_valid_d;
    logic                      slave_ready_q, slave_ready_d;
    logic [CNT_WIDTH-1:0]      pkt_count_q, pkt_count_d;

    logic                      accept;
    logic                      handshake;
    logic [LEN_WIDTH-1:0]      eff_len;
    logic                      last_tag;

    // Framing: the length is taken from pkt_len_in only at the start of a
    // packet, so mid-packet changes affect the next packet onwards.
    always_comb begin
        accept     = slave_valid_in & slave_ready_q;
        handshake  = out_valid_q & master_ready_out;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;

        if (state_q == IDLE) begin
            eff_len = (pkt_len_in == '0) ? LEN_WIDTH'(1) : pkt_len_in;
        end else begin
            eff_len = len_q;
        end
        last_tag = (beat_cnt_q == (eff_len - LEN_WIDTH'(1))) | flush_in;

        if (accept) begin
            if (state_q == IDLE) begin
                len_d = eff_len;
            end
            if (last_tag) begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                state_d    = IN_PKT;
            end
        end
    end

    // Skid buffer: ready is the registered inverse of the skid occupancy, so
    // a beat can only be accepted while the skid is empty. A beat accepted
    // while the output register is stalled parks in the skid and ready drops.
    always_comb begin
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;

        if (skid_valid_q) begin
            if (handshake) begin
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || handshake) begin
                out_data_d  = slave_data_in;
                out_last_d  = last_tag;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = slave_data_in;
                skid_last_d  = last_tag;
                skid_valid_d = 1'b1;
            end
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end

        slave_ready_d = !skid_valid_d;
        pkt_count_d   = pkt_count_q + CNT_WIDTH'(handshake & out_last_q);
    end

    // State register; reset discards any partial packet and buffered beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            len_q         <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            skid_data_q   <= '0;
            skid_last_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            slave_ready_q <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            len_q         <= len_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            skid_data_q   <= skid_data_d;
            skid_last_q   <= skid_last_d;
            skid_valid_q  <= skid_valid_d;
            slave_ready_q <= slave_ready_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign slave_ready_in   = slave_ready_q;
    assign master_data_out  = out_data_q;
    assign master_last_out  = out_last_q;
    assign master_valid_out = out_valid_q;
    assign pkt_count_out    = pkt_count_q;
    assign in_packet_out    = (state_q == IN_PKT);

endmodule

// File: tb/tb_axi_stream_packetizer.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_packetizer
//
// Purpose:
//   Directed, table-driven bench for axi_stream_packetizer. Each record holds
//   the inputs for one clock and the outputs expected just after that edge.
//   A hand-written sequence covers asynchronous reset with the skid full.
// ---------------------------------------------------------------------------
module tb_axi_stream_packetizer;

    logic        clk;
    logic        rst;
    logic [31:0] slave_data_in;
    logic        slave_valid_in;
    logic        slave_ready_in;
    logic [15:0] pkt_len_in;
    logic        flush_in;
    logic [31:0] master_data_out;
    logic        master_valid_out;
    logic        master_last_out;
    logic        master_ready_out;
    logic [31:0] pkt_count_out;
    logic        in_packet_out;

    int vectorsApplied = 0;
    int miscompares    = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [15:0] len;
        logic        fl;
        logic        mr;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic        er;
        logic [31:0] ecnt;
        logic        ein;
    } vec_t;

    vec_t vecs[$];

    axi_stream_packetizer #(
        .AXI_DATA_WIDTH(32),
        .LEN_WIDTH     (16),
        .CNT_WIDTH     (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .slave_data_in   (slave_data_in),
        .slave_valid_in  (slave_valid_in),
        .slave_ready_in  (slave_ready_in),
        .pkt_len_in      (pkt_len_in),
        .flush_in        (flush_in),
        .master_data_out (master_data_out),
        .master_valid_out(master_valid_out),
        .master_last_out (master_last_out),
        .master_ready_out(master_ready_out),
        .pkt_count_out   (pkt_count_out),
        .in_packet_out   (in_packet_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [31:0] d,
                                input logic [15:0] len, input logic fl,
                                input logic mr, input logic ev,
                                input logic [31:0] ed, input logic el,
                                input logic er, input logic [31:0] ecnt,
                                input logic ein);
        vec_t t;
        t.v = v; t.d = d; t.len = len; t.fl = fl; t.mr = mr;
        t.ev = ev; t.ed = ed; t.el = el; t.er = er; t.ecnt = ecnt; t.ein = ein;
        return t;
    endfunction

    task automatic cmp(input string name, input int idx, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s #%0d %s got 0x%0h want 0x%0h",
                     name, idx, field, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        slave_valid_in   = t.v;
        slave_data_in    = t.d;
        pkt_len_in       = t.len;
        flush_in         = t.fl;
        master_ready_out = t.mr;
    endtask

    // Data and last are only meaningful while valid is high.
    task automatic checkOutput(input vec_t t, input string name, input int idx);
        vectorsApplied++;
        cmp(name, idx, "master_valid_out", 32'(master_valid_out), 32'(t.ev));
        cmp(name, idx, "slave_ready_in", 32'(slave_ready_in), 32'(t.er));
        cmp(name, idx, "pkt_count_out", pkt_count_out, t.ecnt);
        cmp(name, idx, "in_packet_out", 32'(in_packet_out), 32'(t.ein));
        if (t.ev) begin
            cmp(name, idx, "master_data_out", master_data_out, t.ed);
            cmp(name, idx, "master_last_out", 32'(master_last_out), 32'(t.el));
        end
    endtask

    task automatic checkReset(input string name);
        vectorsApplied++;
        cmp(name, 0, "master_valid_out", 32'(master_valid_out), 32'd0);
        cmp(name, 0, "master_last_out", 32'(master_last_out), 32'd0);
        cmp(name, 0, "master_data_out", master_data_out, 32'd0);
        cmp(name, 0, "slave_ready_in", 32'(slave_ready_in), 32'd0);
        cmp(name, 0, "pkt_count_out", pkt_count_out, 32'd0);
        cmp(name, 0, "in_packet_out", 32'(in_packet_out), 32'd0);
    endtask

    task automatic cycle(input vec_t t, input string name, input int idx);
        applyStimulus(t);
        @(posedge clk);
        #1;
        checkOutput(t, name, idx);
    endtask

    initial begin
        // Fields: v, d, len, fl, mr | ev, ed, el, er, cnt, in_pkt
        // Release edge: ready rises, nothing accepted.
        vecs.push_back(mk(0, 0, 4, 0, 1, 0, 0, 0, 1, 0, 0));
        // len 4, eight back-to-back beats
        vecs.push_back(mk(1, 32'h1, 4, 0, 1, 1, 32'h1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 32'h2, 4, 0, 1, 1, 32'h2, 0, 1, 0, 1));
        vecs.push_back(mk(1, 32'h3, 4, 0, 1, 1, 32'h3, 0, 1, 0, 1));
        vecs.push_back(mk(1, 32'h4, 4, 0, 1, 1, 32'h4, 1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h5, 4, 0, 1, 1, 32'h5, 0, 1, 1, 1));
        vecs.push_back(mk(1, 32'h6, 4, 0, 1, 1, 32'h6, 0, 1, 1, 1));
        vecs.push_back(mk(1, 32'h7, 4, 0, 1, 1, 32'h7, 0, 1, 1, 1));
        vecs.push_back(mk(1, 32'h8, 4, 0, 1, 1, 32'h8, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 4, 0, 1, 0, 0, 0, 1, 2, 0));
        // backpressure: ready low 3 clocks, second beat parks in the skid
        vecs.push_back(mk(1, 32'h11, 4, 0, 1, 1, 32'h11, 0, 1, 2, 1));
        vecs.push_back(mk(1, 32'h12, 4, 0, 0, 1, 32'h11, 0, 0, 2, 1));
        vecs.push_back(mk(1, 32'h13, 4, 0, 0, 1, 32'h11, 0, 0, 2, 1));
        vecs.push_back(mk(1, 32'h13, 4, 0, 0, 1, 32'h11, 0, 0, 2, 1));
        vecs.push_back(mk(1, 32'h13, 4, 0, 1, 1, 32'h12, 0, 1, 2, 1));
        vecs.push_back(mk(1, 32'h13, 4, 0, 1, 1, 32'h13, 0, 1, 2, 1));
        vecs.push_back(mk(1, 32'h14, 4, 0, 1, 1, 32'h14, 1, 1, 2, 0));
        vecs.push_back(mk(1, 32'h15, 4, 0, 1, 1, 32'h15, 0, 1, 3, 1));
        vecs.push_back(mk(1, 32'h16, 4, 0, 1, 1, 32'h16, 0, 1, 3, 1));
        vecs.push_back(mk(1, 32'h17, 4, 0, 1, 1, 32'h17, 0, 1, 3, 1));
        vecs.push_back(mk(1, 32'h18, 4, 0, 1, 1, 32'h18, 1, 1, 3, 0));
        vecs.push_back(mk(0, 0, 4, 0, 1, 0, 0, 0, 1, 4, 0));
        // length changes 4->2 on beat 2: current packet still 4 beats
        vecs.push_back(mk(1, 32'h21, 4, 0, 1, 1, 32'h21, 0, 1, 4, 1));
        vecs.push_back(mk(1, 32'h22, 2, 0, 1, 1, 32'h22, 0, 1, 4, 1));
        vecs.push_back(mk(1, 32'h23, 2, 0, 1, 1, 32'h23, 0, 1, 4, 1));
        vecs.push_back(mk(1, 32'h24, 2, 0, 1, 1, 32'h24, 1, 1, 4, 0));
        vecs.push_back(mk(1, 32'h25, 2, 0, 1, 1, 32'h25, 0, 1, 5, 1));
        vecs.push_back(mk(1, 32'h26, 2, 0, 1, 1, 32'h26, 1, 1, 5, 0));
        vecs.push_back(mk(1, 32'h27, 2, 0, 1, 1, 32'h27, 0, 1, 6, 1));
        vecs.push_back(mk(1, 32'h28, 2, 0, 1, 1, 32'h28, 1, 1, 6, 0));
        vecs.push_back(mk(0, 0, 2, 0, 1, 0, 0, 0, 1, 7, 0));
        // flush on beat 3 of a len-8 packet, then a len-3 packet
        vecs.push_back(mk(1, 32'h31, 8, 0, 1, 1, 32'h31, 0, 1, 7, 1));
        vecs.push_back(mk(1, 32'h32, 8, 0, 1, 1, 32'h32, 0, 1, 7, 1));
        vecs.push_back(mk(1, 32'h33, 8, 1, 1, 1, 32'h33, 1, 1, 7, 0));
        vecs.push_back(mk(1, 32'h34, 3, 0, 1, 1, 32'h34, 0, 1, 8, 1));
        vecs.push_back(mk(1, 32'h35, 3, 0, 1, 1, 32'h35, 0, 1, 8, 1));
        vecs.push_back(mk(1, 32'h36, 3, 0, 1, 1, 32'h36, 1, 1, 8, 0));
        vecs.push_back(mk(0, 0, 3, 1, 1, 0, 0, 0, 1, 9, 0));
        // flush without a beat is ignored mid-packet
        vecs.push_back(mk(1, 32'h41, 3, 0, 1, 1, 32'h41, 0, 1, 9, 1));
        vecs.push_back(mk(0, 0, 3, 1, 1, 0, 0, 0, 1, 9, 1));
        vecs.push_back(mk(1, 32'h42, 3, 0, 1, 1, 32'h42, 0, 1, 9, 1));
        vecs.push_back(mk(1, 32'h43, 3, 0, 1, 1, 32'h43, 1, 1, 9, 0));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0, 1, 10, 0));
        // len 0 and len 1: every beat is last
        vecs.push_back(mk(1, 32'h51, 0, 0, 1, 1, 32'h51, 1, 1, 10, 0));
        vecs.push_back(mk(1, 32'h52, 0, 0, 1, 1, 32'h52, 1, 1, 11, 0));
        vecs.push_back(mk(1, 32'h53, 1, 0, 1, 1, 32'h53, 1, 1, 12, 0));
        vecs.push_back(mk(1, 32'h54, 1, 0, 1, 1, 32'h54, 1, 1, 13, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 14, 0));

        // Reset state
        rst              = 1'b0;
        slave_valid_in   = 1'b0;
        slave_data_in    = '0;
        pkt_len_in       = 16'd4;
        flush_in         = 1'b0;
        master_ready_out = 1'b0;
        #2;
        checkReset("reset_init");
        #20;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i], "table", i);
        end

        // Reset mid-packet with the skid full
        cycle(mk(1, 32'h61, 4, 0, 0, 1, 32'h61, 0, 1, 14, 1), "skidfill", 0);
        cycle(mk(1, 32'h62, 4, 0, 0, 1, 32'h61, 0, 0, 14, 1), "skidfill", 1);
        cycle(mk(1, 32'h63, 4, 0, 0, 1, 32'h61, 0, 0, 14, 1), "skidfill", 2);
        rst = 1'b0;
        #1;
        checkReset("reset_mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle(mk(1, 32'h71, 4, 0, 1, 0, 0, 0, 1, 0, 0), "postreset", 0);
        cycle(mk(1, 32'h71, 4, 0, 1, 1, 32'h71, 0, 1, 0, 1), "postreset", 1);
        cycle(mk(1, 32'h72, 4, 0, 1, 1, 32'h72, 0, 1, 0, 1), "postreset", 2);
        cycle(mk(1, 32'h73, 4, 0, 1, 1, 32'h73, 0, 1, 0, 1), "postreset", 3);
        cycle(mk(1, 32'h74, 4, 0, 1, 1, 32'h74, 1, 1, 0, 0), "postreset", 4);
        cycle(mk(0, 0, 4, 0, 1, 0, 0, 0, 1, 1, 0), "postreset", 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
